timekeeper_fsm: RTL

//  Parametrised mode controller and timebase for the digital-clock top level.

---
 rtl/timekeeper_fsm.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/timekeeper_fsm.sv
// timekeeper_fsm: time-of-day timebase with alarms, hourly chime and RUN/SET_TIME/SET_ALARM mode control
module timekeeper_fsm #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int NUM_ALARMS = 2,
    parameter int ALARM_SECS = 60,
    parameter int CHIME_SECS = 2,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_mode,
    input  logic                  btn_next,
    input  logic                  btn_inc,
    input  logic                  btn_dec,
    input  logic [NUM_ALARMS-1:0] alarm_en,
    input  logic                  chime_en,
    output logic [1:0]            mode,
    output logic [2:0]            edit_sel,
    output logic [5:0]            hour,
    output logic [5:0]            minute,
    output logic [5:0]            second,
    output logic [5:0]            sel_al_hour,
    output logic [5:0]            sel_al_min,
    output logic                  sec_tick,
    output logic                  blink,
    output logic [NUM_ALARMS-1:0] alarm_hit,
    output logic                  chime
);
    typedef enum logic [1:0] {RUN = 2'd0, SET_TIME = 2'd1, SET_ALARM = 2'd2} state_t;
    localparam int PW = $clog2(CLK_HZ);
    localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    localparam int AW = $clog2(ALARM_SECS + 1);
    localparam int CW = $clog2(CHIME_SECS + 1);

    state_t                state, state_d;
    logic [2:0]            sel_d;
    logic [5:0]            hour_d, minute_d, second_d, t_min, t_hour;
    logic [5:0]            al_h [4], al_m [4], al_h_d [4], al_m_d [4];
    logic [PW-1:0]         presc, presc_d;
    logic [BW-1:0]         bcnt, bcnt_d;
    logic [CW-1:0]         ccnt, ccnt_d;
    logic [AW-1:0]         acnt [NUM_ALARMS], acnt_d [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] hit_d;
    logic                  blink_d, chime_d, run, s_wrap, m_wrap, fld, chg, bwrap;
    logic [1:0]            idx;

    function automatic logic [5:0] stp(input logic [5:0] v, input logic [5:0] mx, input logic up);
        return up ? (v == mx ? 6'd0 : v + 6'd1) : (v == 6'd0 ? mx : v - 6'd1);
    endfunction

    assign run         = state == RUN;
    assign mode        = state;
    assign sec_tick    = run && presc == PW'(CLK_HZ - 1);
    assign s_wrap      = second == 6'd59;
    assign m_wrap      = minute == 6'd59;
    assign t_min       = m_wrap ? 6'd0 : minute + 6'd1;
    assign t_hour      = !m_wrap ? hour : hour == 6'd23 ? 6'd0 : hour + 6'd1;
    assign fld         = edit_sel[0];
    assign idx         = edit_sel[2:1];
    assign sel_al_hour = al_h[idx];
    assign sel_al_min  = al_m[idx];

    always_comb begin
        state_d  = state;
        sel_d    = edit_sel;
        second_d = sec_tick ? (s_wrap ? 6'd0 : second + 6'd1) : second;
        minute_d = sec_tick && s_wrap ? t_min : minute;
        hour_d   = sec_tick && s_wrap ? t_hour : hour;
        al_h_d   = al_h;
        al_m_d   = al_m;
        acnt_d   = acnt;
        hit_d    = alarm_hit;
        ccnt_d   = ccnt;
        chime_d  = chime;
        if (btn_mode) begin
            state_d = run ? SET_TIME : state == SET_TIME ? SET_ALARM : RUN;
            sel_d   = 3'd0;
            if (run) second_d = 6'd0;
        end else if (!run) begin
            if (btn_next)
                sel_d = state == SET_TIME ? {2'd0, !fld} : !fld ? {idx, 1'b1} :
                        {idx == 2'(NUM_ALARMS - 1) ? 2'd0 : idx + 2'd1, 1'b0};
            if (btn_inc ^ btn_dec) begin
                if (state == SET_TIME && !fld) hour_d = stp(hour, 6'd23, btn_inc);
                if (state == SET_TIME && fld) minute_d = stp(minute, 6'd59, btn_inc);
                if (state == SET_ALARM && !fld) al_h_d[idx] = stp(al_h[idx], 6'd23, btn_inc);
                if (state == SET_ALARM && fld) al_m_d[idx] = stp(al_m[idx], 6'd59, btn_inc);
            end
        end
        presc_d = run && state_d == RUN && !sec_tick ? presc + PW'(1) : '0;
        chg     = state_d != state || sel_d != edit_sel;
        bwrap   = bcnt == BW'(BLINK_DIV - 1);
        blink_d = state_d == RUN ? 1'b0 : chg ? 1'b1 : bwrap ? !blink : blink;
        bcnt_d  = state_d == RUN || chg || bwrap ? '0 : bcnt + BW'(1);
        // a fresh match reloads the ring count even if the alarm is already ringing
        for (int k = 0; k < NUM_ALARMS; k++) begin
            if (!alarm_en[k] || state_d != RUN || btn_next) hit_d[k] = 1'b0;
            else if (sec_tick && s_wrap && t_hour == al_h[k] && t_min == al_m[k]) begin
                hit_d[k]  = 1'b1;
                acnt_d[k] = AW'(ALARM_SECS);
            end else if (sec_tick && alarm_hit[k]) begin
                hit_d[k]  = acnt[k] != AW'(1);
                acnt_d[k] = acnt[k] - AW'(1);
            end
        end
        if (!chime_en || state_d != RUN) chime_d = 1'b0;
        else if (sec_tick && s_wrap && m_wrap) begin
            chime_d = 1'b1;
            ccnt_d  = CW'(CHIME_SECS);
        end else if (sec_tick && chime) begin
            chime_d = ccnt != CW'(1);
            ccnt_d  = ccnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            edit_sel  <= '0;
            hour      <= '0;
            minute    <= '0;
            second    <= '0;
            al_h      <= '{default: 6'd0};
            al_m      <= '{default: 6'd0};
            presc     <= '0;
            bcnt      <= '0;
            blink     <= 1'b0;
            acnt      <= '{default: '0};
            alarm_hit <= '0;
            ccnt      <= '0;
            chime     <= 1'b0;
        end else begin
            state     <= state_d;
            edit_sel  <= sel_d;
            hour      <= hour_d;
            minute    <= minute_d;
            second    <= second_d;
            al_h      <= al_h_d;
            al_m      <= al_m_d;
            presc     <= presc_d;
            bcnt      <= bcnt_d;
            blink     <= blink_d;
            acnt      <= acnt_d;
            alarm_hit <= hit_d;
            ccnt      <= ccnt_d;
            chime     <= chime_d;
        end
    end
endmodule
